// File: rtl/rnd_pkg.sv
// Shared definitions for the 17-bit rnd generator and the checker that tracks it.
// Holds the sample/state widths, the feedback taps and the checker FSM state type.
package rnd_pkg;

    localparam int N_BITS     = 16;
    localparam int STATE_BITS = 17;

    localparam int TAP_A = 16;
    localparam int TAP_B = 15;
    localparam int TAP_C = 13;
    localparam int TAP_D = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // The one generator bit that never appears in a sample (bit 16) shows up
    // as the top bit of the following sample, so two samples pin down the state.
    function automatic logic [STATE_BITS-1:0] seed_state(
        input logic [N_BITS-1:0] s1,
        input logic [N_BITS-1:0] seed
    );
        return {s1[N_BITS-1], seed};
    endfunction

endpackage

// File: rtl/rnd_step.sv
// One combinational advance of the 17-bit rnd generator state.
module rnd_step
    import rnd_pkg::*;
(
    input  logic [STATE_BITS-1:0] i_state,
    output logic [STATE_BITS-1:0] o_state
);

    logic w_feedback;

    assign w_feedback = i_state[TAP_A] ^ i_state[TAP_B] ^ i_state[TAP_C] ^ i_state[TAP_D];
    assign o_state    = {w_feedback, i_state[STATE_BITS-1:1]};

endmodule

// File: rtl/rnd_check.sv
// Locks onto the rnd generator from two observed samples, then predicts and checks
// every following sample, dropping lock after LOSS_THRESH consecutive mismatches.
module rnd_check
    import rnd_pkg::*;
#(
    parameter int LOSS_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [N_BITS-1:0] sample,
    input  logic              clear,
    output logic              locked,
    output logic              err,
    output logic [15:0]       err_count,
    output logic [31:0]       check_count
);

    // The miss counter only ever holds 0..LOSS_THRESH-1; reaching the threshold drops lock.
    localparam int            MW        = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_THRESH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [N_BITS-1:0]     r_seed;
    logic [N_BITS-1:0]     w_seed_next;
    logic [STATE_BITS-1:0] r_pred;
    logic [STATE_BITS-1:0] w_pred_next;
    logic [MW-1:0]         r_miss;
    logic [MW-1:0]         w_miss_next;
    logic                  r_locked;
    logic                  w_locked_next;
    logic                  r_err;
    logic                  w_err_next;
    logic                  w_compare;
    logic                  w_mismatch;
    logic [15:0]           r_err_count;
    logic [15:0]           w_err_base;
    logic [15:0]           w_err_count_next;
    logic [31:0]           r_check_count;
    logic [31:0]           w_check_base;
    logic [31:0]           w_check_count_next;
    logic [STATE_BITS-1:0] w_step_in;
    logic [STATE_BITS-1:0] w_step_one;
    logic [STATE_BITS-1:0] w_step_two;

    // The two steppers are chained: in SEED they double-step the reconstructed
    // state, otherwise the first one alone advances the running predictor.
    assign w_step_in = (r_state == SEED) ? seed_state(sample, r_seed) : r_pred;

    rnd_step u_step_one (
        .i_state (w_step_in),
        .o_state (w_step_one)
    );

    rnd_step u_step_two (
        .i_state (w_step_one),
        .o_state (w_step_two)
    );

    always_comb begin
        w_state_next  = r_state;
        w_seed_next   = r_seed;
        w_pred_next   = r_pred;
        w_miss_next   = r_miss;
        w_locked_next = r_locked;
        w_err_next    = 1'b0;
        w_compare     = 1'b0;
        w_mismatch    = 1'b0;
        if (valid) begin
            case (r_state)
                IDLE: begin
                    w_seed_next  = sample;
                    w_state_next = SEED;
                end
                SEED: begin
                    w_pred_next   = w_step_two;
                    w_locked_next = 1'b1;
                    w_state_next  = LOCKED;
                end
                LOCKED: begin
                    w_compare   = 1'b1;
                    w_pred_next = w_step_one;
                    if (sample != r_pred[N_BITS-1:0]) begin
                        w_mismatch = 1'b1;
                        w_err_next = 1'b1;
                        if (r_miss == MISS_LAST) begin
                            w_state_next  = IDLE;
                            w_locked_next = 1'b0;
                            w_miss_next   = '0;
                        end else begin
                            w_miss_next = r_miss + 1'b1;
                        end
                    end else begin
                        w_miss_next = '0;
                    end
                end
                default: begin
                    w_state_next  = IDLE;
                    w_locked_next = 1'b0;
                end
            endcase
        end
    end

    // clear zeroes the totals before this cycle's own increment is added on top.
    assign w_err_base         = clear ? '0 : r_err_count;
    assign w_check_base       = clear ? '0 : r_check_count;
    assign w_err_count_next   = (w_mismatch && (w_err_base != '1)) ? w_err_base + 16'd1 : w_err_base;
    assign w_check_count_next = (w_compare && (w_check_base != '1)) ? w_check_base + 32'd1 : w_check_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed        <= '0;
            r_pred        <= '0;
            r_miss        <= '0;
            r_locked      <= 1'b0;
            r_err         <= 1'b0;
            r_err_count   <= '0;
            r_check_count <= '0;
        end else begin
            r_seed        <= w_seed_next;
            r_pred        <= w_pred_next;
            r_miss        <= w_miss_next;
            r_locked      <= w_locked_next;
            r_err         <= w_err_next;
            r_err_count   <= w_err_count_next;
            r_check_count <= w_check_count_next;
        end
    end

    assign locked      = r_locked;
    assign err         = r_err;
    assign err_count   = r_err_count;
    assign check_count = r_check_count;

endmodule
